// File: rtl/dsadc_pkg.sv
// Shared types and default parameters for the dual-slope conversion sequencer.
package dsadc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_AZ    = 3'd1,
    ST_BBM1  = 3'd2,
    ST_INT   = 3'd3,
    ST_BBM2  = 3'd4,
    ST_DEINT = 3'd5,
    ST_DONE  = 3'd6
  } dsadc_state_t;

  localparam int DEF_CNT_WIDTH  = 16;
  localparam int DEF_AZ_COUNT   = 500;
  localparam int DEF_INT_COUNT  = 1000;
  localparam int DEF_MAX_DEINT  = 2000;
  localparam int DEF_FILTER_LAT = 15;

endpackage

// File: rtl/dual_slope_ctrl.sv
// Dual-slope ADC sequencer: autozero, integrate, deintegrate with timeout.
// Optional DSADC_LATENCY_COMP_EN subtracts the comparator filter latency from the count.
module dual_slope_ctrl
  import dsadc_pkg::*;
#(
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int AZ_COUNT   = DEF_AZ_COUNT,
  parameter int INT_COUNT  = DEF_INT_COUNT,
  parameter int MAX_DEINT  = DEF_MAX_DEINT,
  parameter int FILTER_LAT = DEF_FILTER_LAT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 cmp_i,
  output logic                 az_sw_o,
  output logic                 int_sw_o,
  output logic                 ref_pos_sw_o,
  output logic                 ref_neg_sw_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] result_o,
  output logic                 pol_o,
  output logic                 ovf_o
);

  if (AZ_COUNT < 1 || INT_COUNT < 1 || FILTER_LAT < 0 ||
      longint'(MAX_DEINT) >= (longint'(1) << CNT_WIDTH) ||
      longint'(AZ_COUNT)  >  (longint'(1) << CNT_WIDTH) ||
      longint'(INT_COUNT) >  (longint'(1) << CNT_WIDTH)) begin : g_param_err
    $error("dual_slope_ctrl: illegal parameter combination");
  end

  localparam logic [CNT_WIDTH-1:0] AZ_LAST  = CNT_WIDTH'(AZ_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] INT_LAST = CNT_WIDTH'(INT_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT  = CNT_WIDTH'(MAX_DEINT);
`ifdef DSADC_LATENCY_COMP_EN
  localparam logic [CNT_WIDTH-1:0] LAT_CNT  = CNT_WIDTH'(FILTER_LAT);
`endif

  dsadc_state_t         state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pol_q, pol_d;
  logic                 finish;
  logic                 fin_ovf;
  logic [CNT_WIDTH-1:0] fin_res;
  logic [CNT_WIDTH-1:0] res_adj;
  logic [CNT_WIDTH-1:0] result_q;
  logic                 pol_out_q;
  logic                 ovf_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pol_q     <= 1'b0;
      result_q  <= '0;
      pol_out_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pol_q   <= pol_d;
      if (finish) begin
        result_q  <= res_adj;
        pol_out_q <= pol_q;
        ovf_q     <= fin_ovf;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pol_d   = pol_q;
    finish  = 1'b0;
    fin_ovf = 1'b0;
    fin_res = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_AZ;
          cnt_d   = '0;
        end
      end
      ST_AZ: begin
        if (cnt_q == AZ_LAST) begin
          state_d = ST_BBM1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_BBM1: begin
        state_d = ST_INT;
        cnt_d   = '0;
      end
      ST_INT: begin
        if (cnt_q == INT_LAST) begin
          pol_d   = cmp_i;
          state_d = ST_BBM2;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_BBM2: begin
        state_d = ST_DEINT;
        cnt_d   = '0;
      end
      ST_DEINT: begin
        // A comparator flip wins over the timeout when both land on the same edge.
        if (cmp_i != pol_q) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_q == MAX_CNT) begin
          finish  = 1'b1;
          fin_ovf = 1'b1;
          fin_res = MAX_CNT;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    res_adj = fin_res;
`ifdef DSADC_LATENCY_COMP_EN
    if (!fin_ovf) res_adj = (fin_res > LAT_CNT) ? fin_res - LAT_CNT : '0;
`endif
  end

  // done_o is a one-cycle valid with no ready: the reader must take
  // result_o/pol_o/ovf_o on that cycle or later, they hold until the next done_o.
  always_comb begin
    az_sw_o      = (state_q == ST_IDLE) || (state_q == ST_AZ);
    int_sw_o     = (state_q == ST_INT);
    ref_neg_sw_o = (state_q == ST_DEINT) && pol_q;
    ref_pos_sw_o = (state_q == ST_DEINT) && !pol_q;
    busy_o       = (state_q != ST_IDLE);
    done_o       = (state_q == ST_DONE);
  end

  assign result_o = result_q;
  assign pol_o    = pol_out_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Randomized scoreboard bench for dual_slope_ctrl (small phase lengths).
module tb_dual_slope_ctrl;

  localparam int CW  = 16;
  localparam int AZ  = 4;
  localparam int INT = 8;
  localparam int MAX = 20;
  localparam int FL  = 3;
  localparam int W   = CW + 2;

  logic          clk = 1'b0;
  logic          rst_i, start_i, cmp_i;
  logic          az_sw_o, int_sw_o, ref_pos_sw_o, ref_neg_sw_o;
  logic          busy_o, done_o, pol_o, ovf_o;
  logic [CW-1:0] result_o;

  logic [W-1:0]  exp_q[$];
  int            checks = 0;
  int            passes = 0;

  dual_slope_ctrl #(
    .CNT_WIDTH(CW), .AZ_COUNT(AZ), .INT_COUNT(INT),
    .MAX_DEINT(MAX), .FILTER_LAT(FL)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .cmp_i(cmp_i),
    .az_sw_o(az_sw_o), .int_sw_o(int_sw_o),
    .ref_pos_sw_o(ref_pos_sw_o), .ref_neg_sw_o(ref_neg_sw_o),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
    .pol_o(pol_o), .ovf_o(ovf_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d so far", passes, checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // reference model: result word {ovf, pol, result} from input polarity and flip cycle
  function automatic logic [W-1:0] model(input logic pol, input int flip);
    int   res;
    logic ovf;
    if (flip == 0 || flip > MAX + 1) begin
      res = MAX;
      ovf = 1'b1;
    end else begin
      res = flip - 1;
      ovf = 1'b0;
    end
`ifdef DSADC_LATENCY_COMP_EN
    if (!ovf) res = (res > FL) ? res - FL : 0;
`endif
    return {ovf, pol, CW'(res)};
  endfunction

  // checks {az,int,pos,neg,busy,done} at negedge, then advances to just after the next posedge
  task automatic expect_cycle(input string name, input logic [3:0] sw, input logic busy,
                              input logic done);
    @(negedge clk);
    check(name, {58'd0, az_sw_o, int_sw_o, ref_pos_sw_o, ref_neg_sw_o, busy_o, done_o},
          {58'd0, sw, busy, done});
    @(posedge clk);
    #1;
  endtask

  // mode 0: start pulse; 1: extra start pulse during INT; 2: start held high.
  // flip: DEINT cycle on which cmp_i turns (0 = never). abort_at: DEINT cycle to reset in.
  task automatic run_conv(input logic pol, input int flip, input int mode, input int abort_at);
    logic [3:0] deint_sw;
    deint_sw = pol ? 4'b0001 : 4'b0010;
    if (abort_at == 0) exp_q.push_back(model(pol, flip));
    start_i = 1'b1;
    cmp_i   = 1'($urandom_range(0, 1));
    expect_cycle("idle", 4'b1000, 1'b0, 1'b0);
    if (mode != 2) start_i = 1'b0;
    for (int i = 0; i < AZ; i++) begin
      cmp_i = 1'($urandom_range(0, 1));
      expect_cycle("az", 4'b1000, 1'b1, 1'b0);
    end
    cmp_i = pol;
    expect_cycle("bbm1", 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < INT; i++) begin
      if (mode == 1) start_i = (i == 3);
      expect_cycle("int", 4'b0100, 1'b1, 1'b0);
    end
    start_i = (mode == 2);
    expect_cycle("bbm2", 4'b0000, 1'b1, 1'b0);
    for (int j = 1; j <= MAX + 1; j++) begin
      cmp_i = (flip != 0 && j >= flip) ? !pol : pol;
      if (j == abort_at) begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        #1;
        check("abort_outputs",
              {42'd0, az_sw_o, int_sw_o, ref_pos_sw_o, ref_neg_sw_o, busy_o, done_o,
               ovf_o, pol_o, result_o},
              {42'd0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        return;
      end
      expect_cycle("deint", deint_sw, 1'b1, 1'b0);
      if (flip != 0 && j == flip) break;
    end
    expect_cycle("done", 4'b0000, 1'b1, 1'b1);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    check("switch_onehot0",
          {63'd0, $onehot0({az_sw_o, int_sw_o, ref_pos_sw_o, ref_neg_sw_o})}, 64'd1);
    if (!rst_i && done_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {63'd0, done_o}, 64'd0);
      end else begin
        logic [W-1:0] exp;
        exp = exp_q.pop_front();
        check("result", {46'd0, ovf_o, pol_o, result_o}, {46'd0, exp});
      end
    end
  end

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    cmp_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {42'd0, az_sw_o, int_sw_o, ref_pos_sw_o, ref_neg_sw_o, busy_o, done_o,
           ovf_o, pol_o, result_o},
          {42'd0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});
    rst_i = 1'b0;

    run_conv(1'b1, 10, 0, 0);        // nominal positive
    run_conv(1'b0, 4, 0, 0);         // negative
    run_conv(1'b1, 0, 0, 0);         // timeout
    run_conv(1'b0, MAX + 1, 0, 0);   // flip on the timeout edge
    run_conv(1'b1, 0, 0, 5);         // reset during DEINT
    run_conv(1'b0, 1, 0, 0);         // immediate flip
    run_conv(1'b1, 7, 1, 0);         // start pulse during INT ignored
    for (int n = 0; n < 12; n++)
      run_conv(1'($urandom_range(0, 1)), int'($urandom_range(0, MAX + 2)),
               int'($urandom_range(0, 1)), 0);
    for (int n = 0; n < 3; n++)      // back-to-back with start held
      run_conv(1'($urandom_range(0, 1)), int'($urandom_range(1, MAX + 2)), 2, 0);
    start_i = 1'b0;
    expect_cycle("idle_end", 4'b1000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
